// File: rtl/decode_queue.sv
// ----------------------------------------------------------------------------
// decode_queue
//
// Decoupling queue between fetch and execute. Raw MIPS instruction words are
// accepted with their PC over a valid/ready handshake. The ALU control code is
// decoded combinationally from op/rt/funct and stored in the entry at push
// time. Entries are presented in strict FIFO order to execute over a second
// valid/ready handshake. A synchronous flush drops everything that is queued.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   PC_W   width of the PC tag carried with each entry
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous queue clear; a push in the same cycle is dropped
//   in_valid/in_ready fetch-side handshake; in_ready = (count != DEPTH)
//   in_inst, in_pc    instruction word and its PC
//   out_valid/out_ready execute-side handshake; out_valid = (count != 0)
//   out_inst, out_pc  head instruction word and PC
//   out_alucontrol    decoded EXE_*_OP code of the head entry
//   out_ri            head entry is a reserved/unrecognised instruction
//   count             current occupancy
//
// Build option
//   DECODE_QUEUE_RI_EN  when defined, a reserved-instruction bit is stored per
//                       entry and driven on out_ri; otherwise out_ri is 0.
// ----------------------------------------------------------------------------
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_inst,
   input  logic [PC_W-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_inst,
   output logic [PC_W-1:0]              out_pc,
   output logic [7:0]                   out_alucontrol,
   output logic                         out_ri,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // ALU control encodings shared with the execute stage
   localparam logic [7:0] EXE_NOP_OP    = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP    = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP     = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP    = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP    = 8'b00100111;
   localparam logic [7:0] EXE_ANDI_OP   = 8'b01011001;
   localparam logic [7:0] EXE_ORI_OP    = 8'b01011010;
   localparam logic [7:0] EXE_XORI_OP   = 8'b01011011;
   localparam logic [7:0] EXE_LUI_OP    = 8'b01011100;
   localparam logic [7:0] EXE_SLL_OP    = 8'b01111100;
   localparam logic [7:0] EXE_SLLV_OP   = 8'b00000100;
   localparam logic [7:0] EXE_SRL_OP    = 8'b00000010;
   localparam logic [7:0] EXE_SRLV_OP   = 8'b00000110;
   localparam logic [7:0] EXE_SRA_OP    = 8'b00000011;
   localparam logic [7:0] EXE_SRAV_OP   = 8'b00000111;
   localparam logic [7:0] EXE_MFHI_OP   = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP   = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP   = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP   = 8'b00010011;
   localparam logic [7:0] EXE_SLT_OP    = 8'b00101010;
   localparam logic [7:0] EXE_SLTU_OP   = 8'b00101011;
   localparam logic [7:0] EXE_SLTI_OP   = 8'b01010111;
   localparam logic [7:0] EXE_SLTIU_OP  = 8'b01011000;
   localparam logic [7:0] EXE_ADD_OP    = 8'b00100000;
   localparam logic [7:0] EXE_ADDU_OP   = 8'b00100001;
   localparam logic [7:0] EXE_SUB_OP    = 8'b00100010;
   localparam logic [7:0] EXE_SUBU_OP   = 8'b00100011;
   localparam logic [7:0] EXE_ADDI_OP   = 8'b01010101;
   localparam logic [7:0] EXE_ADDIU_OP  = 8'b01010110;
   localparam logic [7:0] EXE_MULT_OP   = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP  = 8'b00011001;
   localparam logic [7:0] EXE_DIV_OP    = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP   = 8'b00011011;
   localparam logic [7:0] EXE_J_OP      = 8'b01001111;
   localparam logic [7:0] EXE_JAL_OP    = 8'b01010000;
   localparam logic [7:0] EXE_JALR_OP   = 8'b00001001;
   localparam logic [7:0] EXE_JR_OP     = 8'b00001000;
   localparam logic [7:0] EXE_BEQ_OP    = 8'b01010001;
   localparam logic [7:0] EXE_BGEZ_OP   = 8'b01000001;
   localparam logic [7:0] EXE_BGEZAL_OP = 8'b01001011;
   localparam logic [7:0] EXE_BGTZ_OP   = 8'b01010100;
   localparam logic [7:0] EXE_BLEZ_OP   = 8'b01010011;
   localparam logic [7:0] EXE_BLTZ_OP   = 8'b01000000;
   localparam logic [7:0] EXE_BLTZAL_OP = 8'b01001010;
   localparam logic [7:0] EXE_BNE_OP    = 8'b01010010;
   localparam logic [7:0] EXE_LB_OP     = 8'b11100000;
   localparam logic [7:0] EXE_LBU_OP    = 8'b11100100;
   localparam logic [7:0] EXE_LH_OP     = 8'b11100001;
   localparam logic [7:0] EXE_LHU_OP    = 8'b11100101;
   localparam logic [7:0] EXE_LW_OP     = 8'b11100011;
   localparam logic [7:0] EXE_SB_OP     = 8'b11101000;
   localparam logic [7:0] EXE_SH_OP     = 8'b11101001;
   localparam logic [7:0] EXE_SW_OP     = 8'b11101011;

   // Decode op/rt/funct into the ALU control code; unlisted encodings give NOP.
   function automatic logic [7:0] decode_alu(input logic [31:0] inst);
      logic [7:0] alu;
      alu = EXE_NOP_OP;
      case (inst[31:26])
         6'h00: begin
            case (inst[5:0])
               6'h24:   alu = EXE_AND_OP;
               6'h25:   alu = EXE_OR_OP;
               6'h26:   alu = EXE_XOR_OP;
               6'h27:   alu = EXE_NOR_OP;
               6'h00:   alu = EXE_SLL_OP;
               6'h02:   alu = EXE_SRL_OP;
               6'h03:   alu = EXE_SRA_OP;
               6'h04:   alu = EXE_SLLV_OP;
               6'h06:   alu = EXE_SRLV_OP;
               6'h07:   alu = EXE_SRAV_OP;
               6'h10:   alu = EXE_MFHI_OP;
               6'h11:   alu = EXE_MTHI_OP;
               6'h12:   alu = EXE_MFLO_OP;
               6'h13:   alu = EXE_MTLO_OP;
               6'h20:   alu = EXE_ADD_OP;
               6'h21:   alu = EXE_ADDU_OP;
               6'h22:   alu = EXE_SUB_OP;
               6'h23:   alu = EXE_SUBU_OP;
               6'h2A:   alu = EXE_SLT_OP;
               6'h2B:   alu = EXE_SLTU_OP;
               6'h18:   alu = EXE_MULT_OP;
               6'h19:   alu = EXE_MULTU_OP;
               6'h1A:   alu = EXE_DIV_OP;
               6'h1B:   alu = EXE_DIVU_OP;
               6'h08:   alu = EXE_JR_OP;
               6'h09:   alu = EXE_JALR_OP;
               default: alu = EXE_NOP_OP;
            endcase
         end
         6'h01: begin
            case (inst[20:16])
               5'h00:   alu = EXE_BLTZ_OP;
               5'h01:   alu = EXE_BGEZ_OP;
               5'h10:   alu = EXE_BLTZAL_OP;
               5'h11:   alu = EXE_BGEZAL_OP;
               default: alu = EXE_NOP_OP;
            endcase
         end
         6'h02:   alu = EXE_J_OP;
         6'h03:   alu = EXE_JAL_OP;
         6'h04:   alu = EXE_BEQ_OP;
         6'h05:   alu = EXE_BNE_OP;
         6'h06:   alu = EXE_BLEZ_OP;
         6'h07:   alu = EXE_BGTZ_OP;
         6'h08:   alu = EXE_ADDI_OP;
         6'h09:   alu = EXE_ADDIU_OP;
         6'h0A:   alu = EXE_SLTI_OP;
         6'h0B:   alu = EXE_SLTIU_OP;
         6'h0C:   alu = EXE_ANDI_OP;
         6'h0D:   alu = EXE_ORI_OP;
         6'h0E:   alu = EXE_XORI_OP;
         6'h0F:   alu = EXE_LUI_OP;
         6'h20:   alu = EXE_LB_OP;
         6'h21:   alu = EXE_LH_OP;
         6'h23:   alu = EXE_LW_OP;
         6'h24:   alu = EXE_LBU_OP;
         6'h25:   alu = EXE_LHU_OP;
         6'h28:   alu = EXE_SB_OP;
         6'h29:   alu = EXE_SH_OP;
         6'h2B:   alu = EXE_SW_OP;
         default: alu = EXE_NOP_OP;
      endcase
      return alu;
   endfunction

   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nx_s;
   logic            in_ready_r;
   logic            out_valid_r;
   logic            push_s;
   logic            pop_s;
   logic [7:0]      dec_alu_s;

   logic [31:0]     inst_mem_r [DEPTH];
   logic [PC_W-1:0] pc_mem_r   [DEPTH];
   logic [7:0]      alu_mem_r  [DEPTH];

   // Handshake qualification; flush suppresses both sides for the cycle.
   always_comb begin
      push_s    = in_valid  & in_ready_r  & ~flush;
      pop_s     = out_valid_r & out_ready & ~flush;
      dec_alu_s = decode_alu(in_inst);
   end

   // Next occupancy from the push/pop pair.
   always_comb begin
      count_nx_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nx_s = count_r + CW'(1);
         2'b01:   count_nx_s = count_r - CW'(1);
         default: count_nx_s = count_r;
      endcase
   end

   // Pointers, occupancy and registered handshake flags; reset beats flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_r    <= {AW{1'b0}};
         wr_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r     <= count_nx_s;
         // Flags track the next count so in_ready never sees out_ready combinationally.
         in_ready_r  <= (count_nx_s != CW'(DEPTH));
         out_valid_r <= (count_nx_s != {CW{1'b0}});
      end
   end

   // Entry storage; contents need no reset because out_valid qualifies them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         inst_mem_r[wr_ptr_r] <= in_inst;
         pc_mem_r[wr_ptr_r]   <= in_pc;
         alu_mem_r[wr_ptr_r]  <= dec_alu_s;
      end
   end

`ifdef DECODE_QUEUE_RI_EN
   logic ri_mem_r [DEPTH];

   // Every recognised instruction has a non-NOP code, so NOP marks reserved.
   always_ff @(posedge clk) begin
      if (push_s) begin
         ri_mem_r[wr_ptr_r] <= (dec_alu_s == EXE_NOP_OP);
      end
   end

   assign out_ri = ri_mem_r[rd_ptr_r];
`else
   assign out_ri = 1'b0;
`endif

   assign in_ready       = in_ready_r;
   assign out_valid      = out_valid_r;
   assign count          = count_r;
   assign out_inst       = inst_mem_r[rd_ptr_r];
   assign out_pc         = pc_mem_r[rd_ptr_r];
   assign out_alucontrol = alu_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CW    = $clog2(DEPTH+1);

   localparam logic [7:0] C_NOP = 8'h00, C_AND = 8'h24, C_OR = 8'h25, C_XOR = 8'h26, C_NOR = 8'h27;
   localparam logic [7:0] C_ANDI = 8'h59, C_ORI = 8'h5A, C_XORI = 8'h5B, C_LUI = 8'h5C;
   localparam logic [7:0] C_SLL = 8'h7C, C_SLLV = 8'h04, C_SRL = 8'h02, C_SRLV = 8'h06;
   localparam logic [7:0] C_SRA = 8'h03, C_SRAV = 8'h07, C_MFHI = 8'h10, C_MTHI = 8'h11;
   localparam logic [7:0] C_MFLO = 8'h12, C_MTLO = 8'h13, C_SLT = 8'h2A, C_SLTU = 8'h2B;
   localparam logic [7:0] C_SLTI = 8'h57, C_SLTIU = 8'h58, C_ADD = 8'h20, C_ADDU = 8'h21;
   localparam logic [7:0] C_SUB = 8'h22, C_SUBU = 8'h23, C_ADDI = 8'h55, C_ADDIU = 8'h56;
   localparam logic [7:0] C_MULT = 8'h18, C_MULTU = 8'h19, C_DIV = 8'h1A, C_DIVU = 8'h1B;
   localparam logic [7:0] C_J = 8'h4F, C_JAL = 8'h50, C_JALR = 8'h09, C_JR = 8'h08;
   localparam logic [7:0] C_BEQ = 8'h51, C_BGEZ = 8'h41, C_BGEZAL = 8'h4B, C_BGTZ = 8'h54;
   localparam logic [7:0] C_BLEZ = 8'h53, C_BLTZ = 8'h40, C_BLTZAL = 8'h4A, C_BNE = 8'h52;
   localparam logic [7:0] C_LB = 8'hE0, C_LBU = 8'hE4, C_LH = 8'hE1, C_LHU = 8'hE5;
   localparam logic [7:0] C_LW = 8'hE3, C_SB = 8'hE8, C_SH = 8'hE9, C_SW = 8'hEB;

`ifdef DECODE_QUEUE_RI_EN
   localparam bit RI_BUILD = 1'b1;
`else
   localparam bit RI_BUILD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_ri;
   logic [31:0]     in_inst, out_inst;
   logic [PC_W-1:0] in_pc, out_pc;
   logic [7:0]      out_alucontrol;
   logic [CW-1:0]   count;

   int errors = 0;
   int checks = 0;

   // Reference decode tables: indexed lookups filled from the mnemonic list.
   logic [7:0] op_code [64];  bit op_known [64];
   logic [7:0] fn_code [64];  bit fn_known [64];
   logic [7:0] rt_code [32];  bit rt_known [32];

   typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
   ent_t q[$];

   decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_alucontrol(out_alucontrol), .out_ri(out_ri), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_tables();
      for (int i = 0; i < 64; i++) begin
         op_code[i] = C_NOP; op_known[i] = 1'b0; fn_code[i] = C_NOP; fn_known[i] = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
         rt_code[i] = C_NOP; rt_known[i] = 1'b0;
      end
      op_code[2] = C_J;     op_code[3] = C_JAL;   op_code[4] = C_BEQ;   op_code[5] = C_BNE;
      op_code[6] = C_BLEZ;  op_code[7] = C_BGTZ;  op_code[8] = C_ADDI;  op_code[9] = C_ADDIU;
      op_code[10] = C_SLTI; op_code[11] = C_SLTIU; op_code[12] = C_ANDI; op_code[13] = C_ORI;
      op_code[14] = C_XORI; op_code[15] = C_LUI;  op_code[32] = C_LB;   op_code[33] = C_LH;
      op_code[35] = C_LW;   op_code[36] = C_LBU;  op_code[37] = C_LHU;  op_code[40] = C_SB;
      op_code[41] = C_SH;   op_code[43] = C_SW;
      foreach (op_code[i]) op_known[i] = (op_code[i] != C_NOP);
      fn_code[0] = C_SLL;   fn_code[2] = C_SRL;   fn_code[3] = C_SRA;   fn_code[4] = C_SLLV;
      fn_code[6] = C_SRLV;  fn_code[7] = C_SRAV;  fn_code[8] = C_JR;    fn_code[9] = C_JALR;
      fn_code[16] = C_MFHI; fn_code[17] = C_MTHI; fn_code[18] = C_MFLO; fn_code[19] = C_MTLO;
      fn_code[24] = C_MULT; fn_code[25] = C_MULTU; fn_code[26] = C_DIV; fn_code[27] = C_DIVU;
      fn_code[32] = C_ADD;  fn_code[33] = C_ADDU; fn_code[34] = C_SUB;  fn_code[35] = C_SUBU;
      fn_code[36] = C_AND;  fn_code[37] = C_OR;   fn_code[38] = C_XOR;  fn_code[39] = C_NOR;
      fn_code[42] = C_SLT;  fn_code[43] = C_SLTU;
      foreach (fn_code[i]) fn_known[i] = (fn_code[i] != C_NOP);
      rt_code[0] = C_BLTZ; rt_code[1] = C_BGEZ; rt_code[16] = C_BLTZAL; rt_code[17] = C_BGEZAL;
      foreach (rt_code[i]) rt_known[i] = (rt_code[i] != C_NOP);
   endtask

   function automatic logic [7:0] m_alu(input logic [31:0] w);
      if (w[31:26] == 6'd0) return fn_code[w[5:0]];
      if (w[31:26] == 6'd1) return rt_code[w[20:16]];
      return op_code[w[31:26]];
   endfunction

   function automatic logic m_ri(input logic [31:0] w);
      bit known;
      if (w[31:26] == 6'd0)      known = fn_known[w[5:0]];
      else if (w[31:26] == 6'd1) known = rt_known[w[20:16]];
      else                       known = op_known[w[31:26]];
      return RI_BUILD && !known;
   endfunction

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'h0; in_pc = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
   endtask

   task automatic test_decode_latency();
      in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'hBFC00000;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid: got %b want 1", out_valid); end
      checks++; if (out_alucontrol !== C_ADDU) begin errors++; $display("FAIL lat_alu: got %h want %h", out_alucontrol, C_ADDU); end
      checks++; if (out_pc !== 32'hBFC00000) begin errors++; $display("FAIL lat_pc: got %h want bfc00000", out_pc); end
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL lat_count: got %0d want 1", count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (count !== CW'(0)) begin errors++; $display("FAIL lat_drain: got %0d want 0", count); end
   endtask

   task automatic test_fill_wrap();
      logic [31:0] words [4];
      logic [7:0]  exp_alu [5];
      logic [31:0] exp_pc [5];
      words = '{32'h34020001, 32'h8C430004, 32'h10400002, 32'h04110003};
      exp_alu = '{C_ORI, C_LW, C_BEQ, C_BGEZAL, C_JR};
      exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = words[i]; in_pc = 32'h100 + 32'(4 * i);
         tick();
      end
      checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      in_inst = 32'hDEADBEEF; in_pc = 32'hBAD;
      tick();
      checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fifth_push: count got %0d want 4", count); end
      in_inst = 32'h00000008; in_pc = 32'h200;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         // Cycle 0 is full: jr is refused even though a pop happens; cycle 1 takes it.
         in_valid = (i <= 1);
         checks++; if (out_valid !== 1'b1 || out_alucontrol !== exp_alu[i] || out_pc !== exp_pc[i]) begin
            errors++; $display("FAIL wrap_order[%0d]: got v=%b alu=%h pc=%h want v=1 alu=%h pc=%h",
                               i, out_valid, out_alucontrol, out_pc, exp_alu[i], exp_pc[i]);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== CW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: count got %0d v=%b want 0", count, out_valid); end
   endtask

   task automatic test_simultaneous();
      in_valid = 1'b1; in_inst = 32'h00A62024; in_pc = 32'h300; tick();   // and
      in_inst = 32'h00A62025; in_pc = 32'h304; tick();                     // or
      in_inst = 32'h00A62026; in_pc = 32'h308; out_ready = 1'b1; tick();   // xor with pop
      in_valid = 1'b0;
      checks++; if (count !== CW'(2)) begin errors++; $display("FAIL simul_count: got %0d want 2", count); end
      checks++; if (out_alucontrol !== C_OR || out_pc !== 32'h304) begin errors++; $display("FAIL simul_head1: got %h/%h want %h/304", out_alucontrol, out_pc, C_OR); end
      tick();
      checks++; if (out_alucontrol !== C_XOR || out_pc !== 32'h308) begin errors++; $display("FAIL simul_head2: got %h/%h want %h/308", out_alucontrol, out_pc, C_XOR); end
      tick();
      out_ready = 1'b0;
      checks++; if (count !== CW'(0)) begin errors++; $display("FAIL simul_drain: got %0d want 0", count); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = 32'h24420001; in_pc = 32'h400 + 32'(i); tick();
      end
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre: got %0d want 3", count); end
      flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00000009;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== CW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_clear: count=%0d v=%b r=%b want 0/0/1", count, out_valid, in_ready);
      end
      in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h500; tick(); in_valid = 1'b0;
      checks++; if (count !== CW'(1) || out_alucontrol !== C_SLL || out_ri !== 1'b0 || out_pc !== 32'h500) begin
         errors++; $display("FAIL flush_sll: count=%0d alu=%h ri=%b pc=%h want 1/%h/0/500", count, out_alucontrol, out_ri, out_pc, C_SLL);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_ri();
      in_valid = 1'b1; in_inst = 32'hFC000000; in_pc = 32'h600; tick();
      in_inst = 32'h04050000; in_pc = 32'h604; tick();
      in_valid = 1'b0;
      checks++; if (out_ri !== RI_BUILD || out_alucontrol !== C_NOP) begin errors++; $display("FAIL ri_op3f: ri=%b alu=%h want %b/00", out_ri, out_alucontrol, RI_BUILD); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (out_ri !== RI_BUILD || out_alucontrol !== C_NOP || out_pc !== 32'h604) begin errors++; $display("FAIL ri_regimm: ri=%b alu=%h pc=%h want %b/00/604", out_ri, out_alucontrol, out_pc, RI_BUILD); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0: w[31:26] = 6'd0;
         1: w[31:26] = 6'd1;
         2: w[31:26] = 6'($urandom_range(2, 15));
         default: ;
      endcase
      return w;
   endfunction

   task automatic test_random();
      bit do_push, do_pop;
      q.delete();
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_inst = rand_inst(); in_pc = $urandom;
         checks++; if (in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0) || count !== CW'(q.size())) begin
            errors++; $display("FAIL rnd_state[%0d]: r=%b v=%b cnt=%0d want occupancy %0d", cyc, in_ready, out_valid, count, q.size());
         end
         if (q.size() != 0) begin
            checks++; if (out_inst !== q[0].inst || out_pc !== q[0].pc || out_alucontrol !== m_alu(q[0].inst) || out_ri !== m_ri(q[0].inst)) begin
               errors++; $display("FAIL rnd_head[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", cyc, out_inst, out_pc, out_alucontrol, out_ri,
                                  q[0].inst, q[0].pc, m_alu(q[0].inst), m_ri(q[0].inst));
            end
         end
         do_push = in_valid && (q.size() < DEPTH);
         do_pop  = out_ready && (q.size() > 0);
         tick();
         if (rst || flush) q.delete();
         else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{in_inst, in_pc});
         end
      end
      idle_inputs();
   endtask

   initial begin
      init_tables();
      test_reset();
      test_decode_latency();
      test_fill_wrap();
      test_simultaneous();
      test_flush();
      test_ri();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-cycle ALU op decoder.
- Accepts raw MIPS instruction words and their PCs over a valid/ready handshake, and decodes op/rt/funct into the 8-bit alucontrol code at enqueue.
- Decoded entries are held in a DEPTH-entry FIFO and presented to the execute stage over a second valid/ready handshake.
- Sits between fetch and execute, giving decode/execute decoupling, stall absorption and branch/exception flush.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PC_W, 32, width of the PC tag carried with each entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous queue clear; same-cycle push is dropped.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_inst  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  execute consumes the head.
- out_inst  out  32  head instruction word.
- out_pc  out  PC_W  head PC.
- out_alucontrol  out  8  decoded op of the head, using the EXE_*_OP encodings of defines.vh.
- out_ri  out  1  head is a reserved/unrecognised instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=1): rd_ptr=0, wr_ptr=0, count=0. Next cycle: out_valid=0, in_ready=1, count=0. Entry RAM contents are don't-care; outputs are driven from the head slot but are qualified by out_valid.
- Decode is combinational on in_inst and registered into the entry at the push.
- Decode table is identical to the project ALU decoder:
  - I-type logic/arith ops.
  - J/JAL.
  - BEQ/BNE/BGTZ/BLEZ.
  - REGIMM on rt: BLTZ/BLTZAL/BGEZ/BGEZAL.
  - Loads/stores: LB/LBU/LH/LHU/LW/SB/SH/SW.
  - SPECIAL (op=0) on funct: logic, shift, HI/LO moves, arithmetic, MULT/MULTU, DIV/DIVU, JR/JALR.
  - Anything else decodes to EXE_NOP_OP.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- Latency: an entry pushed at edge N is visible at the outputs after edge N; there is no same-cycle bypass from in_* to out_*.
- Push writes inst, pc, alucontrol and ri to slot wr_ptr; wr_ptr advances by 1 modulo DEPTH.
- Pop advances rd_ptr by 1 modulo DEPTH.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle does not make room until the next cycle; in_ready is not combinationally dependent on out_ready.
- Empty (count=0): out_ready is ignored and nothing is popped.
- Pointer wrap-around: rd_ptr and wr_ptr wrap freely; order is strictly FIFO.
- Flush: rd_ptr=0, wr_ptr=0, count=0 next cycle. Any push and pop in the flush cycle are discarded.
- Reset takes precedence over flush.
- Reset or flush mid-stream: all queued entries are lost, and no stale entry is ever re-presented.
- Head outputs stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: DECODE_QUEUE_RI_EN.
- Defined:
  - out_ri=1 for an entry whose op is not listed.
  - out_ri=1 for op=REGIMM with an unlisted rt.
  - out_ri=1 for op=SPECIAL with an unlisted funct.
  - out_alucontrol for such entries is EXE_NOP_OP.
  - The ri bit is stored per entry, costing 1 extra bit per slot.
- Not defined: out_ri is tied to 0 and no storage is allocated. Unknown instructions still decode to EXE_NOP_OP.
- Word 0x00000000 decodes as EXE_SLL_OP with ri=0 in both builds.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release -> out_valid=0, in_ready=1, count=0.
- Decode latency: push 0x00851021 (addu $2,$4,$5) with pc=0xBFC00000 -> next cycle out_valid=1, out_alucontrol=EXE_ADDU_OP, out_pc=0xBFC00000, count=1.
- Fill and wrap with DEPTH=4:
  - Push 0x34020001 (ori), 0x8C430004 (lw), 0x10400002 (beq), 0x04110003 (bgezal) with out_ready=0 -> count=4, in_ready=0.
  - A 5th push is ignored.
  - Then pop continuously while pushing 0x00000008 (jr) -> outputs in order EXE_ORI_OP, EXE_LW_OP, EXE_BEQ_OP, EXE_BGEZAL_OP, EXE_JR_OP, with correct PCs across pointer wrap.
- Simultaneous push and pop at count=2 -> count stays 2, FIFO order preserved.
- Flush:
  - With count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0.
  - The following push of 0x00000000 emerges as EXE_SLL_OP.
- Reserved instruction:
  - With DECODE_QUEUE_RI_EN, push 0xFC000000 and 0x04050000 (REGIMM, rt=5) -> both out_ri=1, alucontrol=EXE_NOP_OP.
  - Without the macro -> out_ri=0 for both.
